// File: rtl/uart_bus_master.sv
// Serial-host bus initiator: decodes 'W'/'R' commands arriving on uart_rx,
// runs one bus transaction per command and answers on uart_tx.
module uart_bus_master #(
   parameter int unsigned CLOCK_FREQUENCY = 50000000,
   parameter int unsigned UART_BAUD_RATE  = 9600,
   parameter int unsigned BUS_TIMEOUT     = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic [31:0] rw_address,
   input  logic [31:0] read_data,
   output logic        read_request,
   input  logic        read_response,
   output logic [31:0] write_data,
   output logic        write_request,
   input  logic        write_response,
   output logic        busy
);

   localparam int unsigned CYCLES_PER_BAUD = CLOCK_FREQUENCY / UART_BAUD_RATE;
   localparam int CNT_W = $clog2(CYCLES_PER_BAUD + 1);
   localparam int TO_W  = $clog2(BUS_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] BAUD_LAST    = CNT_W'(CYCLES_PER_BAUD - 1);
   localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(CYCLES_PER_BAUD / 2 - 1);
   localparam logic [TO_W-1:0]  TIMEOUT_LAST = TO_W'(BUS_TIMEOUT - 1);

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] ACK       = 8'h06;
   localparam logic [7:0] NAK       = 8'h15;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS_REQ, REPLY} state_t;

   logic             rx_meta;
   logic             rx_sync;
   rx_state_t        rx_state;
   logic [CNT_W-1:0] rx_cnt;
   logic [2:0]       rx_bit;
   logic [7:0]       rx_byte;
   logic             rx_valid;
   logic             rx_ferr;

   state_t           state;
   logic             cmd_write;
   logic [1:0]       byte_cnt;
   logic             req_active;
   logic [TO_W-1:0]  timeout_cnt;
   logic [31:0]      reply_buf;
   logic [1:0]       reply_left;
   logic [9:0]       tx_frame;
   logic [3:0]       tx_bit;
   logic [CNT_W-1:0] tx_cnt;

   logic             start_reply;
   logic [31:0]      reply_word;
   logic [1:0]       reply_extra;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
      end
   end

   // Receiver: any high level during the start bit aborts, so short glitches are dropped.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_byte  <= '0;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               if (!rx_sync) rx_state <= RX_START;
            end
            RX_START: begin
               if (rx_sync) begin
                  rx_state <= RX_IDLE;
               end else if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == BAUD_LAST) begin
                  rx_cnt  <= '0;
                  rx_byte <= {rx_sync, rx_byte[7:1]};
                  rx_bit  <= rx_bit + 1'b1;
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == BAUD_LAST) begin
                  rx_cnt   <= '0;
                  rx_valid <= rx_sync;
                  rx_ferr  <= !rx_sync;
                  rx_state <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   always_comb begin
      start_reply = 1'b0;
      reply_word  = {NAK, 24'h0};
      reply_extra = 2'd0;
      case (state)
         IDLE: begin
            if (rx_valid && rx_byte != CMD_WRITE && rx_byte != CMD_READ) start_reply = 1'b1;
         end
         BUS_REQ: begin
            if (req_active) begin
               if (read_request && read_response) begin
                  start_reply = 1'b1;
                  reply_word  = read_data;
                  reply_extra = 2'd3;
               end else if (write_request && write_response) begin
                  start_reply = 1'b1;
                  reply_word  = {ACK, 24'h0};
               end else if (timeout_cnt == TIMEOUT_LAST) begin
                  start_reply = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Command FSM; it also drives the transmitter so reply bytes chain without idle gaps.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= IDLE;
         busy          <= 1'b0;
         cmd_write     <= 1'b0;
         byte_cnt      <= '0;
         rw_address    <= '0;
         write_data    <= '0;
         read_request  <= 1'b0;
         write_request <= 1'b0;
         req_active    <= 1'b0;
         timeout_cnt   <= '0;
         reply_buf     <= '0;
         reply_left    <= '0;
         tx_frame      <= '1;
         tx_bit        <= '0;
         tx_cnt        <= '0;
         uart_tx       <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (rx_valid && (rx_byte == CMD_WRITE || rx_byte == CMD_READ)) begin
                  cmd_write <= (rx_byte == CMD_WRITE);
                  byte_cnt  <= '0;
                  state     <= ADDR;
                  busy      <= 1'b1;
               end
            end
            ADDR: begin
               if (rx_ferr) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (rx_valid) begin
                  rw_address <= {rw_address[23:0], rx_byte};
                  byte_cnt   <= byte_cnt + 1'b1;
                  if (byte_cnt == 2'd3) state <= cmd_write ? WDATA : BUS_REQ;
               end
            end
            WDATA: begin
               if (rx_ferr) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (rx_valid) begin
                  write_data <= {write_data[23:0], rx_byte};
                  byte_cnt   <= byte_cnt + 1'b1;
                  if (byte_cnt == 2'd3) state <= BUS_REQ;
               end
            end
            BUS_REQ: begin
               if (!req_active) begin
                  req_active    <= 1'b1;
                  timeout_cnt   <= '0;
                  write_request <= cmd_write;
                  read_request  <= !cmd_write;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end
            REPLY: begin
               if (tx_cnt == BAUD_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 4'd9) begin
                     if (reply_left != 2'd0) begin
                        tx_frame   <= {1'b1, reply_buf[31:24], 1'b0};
                        reply_buf  <= {reply_buf[23:0], 8'h00};
                        reply_left <= reply_left - 1'b1;
                        tx_bit     <= '0;
                        uart_tx    <= 1'b0;
                     end else begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        uart_tx <= 1'b1;
                     end
                  end else begin
                     tx_bit   <= tx_bit + 1'b1;
                     tx_frame <= {1'b1, tx_frame[9:1]};
                     uart_tx  <= tx_frame[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase

         // The first reply byte's start bit goes out on the same edge the request drops.
         if (start_reply) begin
            state         <= REPLY;
            busy          <= 1'b1;
            read_request  <= 1'b0;
            write_request <= 1'b0;
            req_active    <= 1'b0;
            tx_frame      <= {1'b1, reply_word[31:24], 1'b0};
            reply_buf     <= {reply_word[23:0], 8'h00};
            reply_left    <= reply_extra;
            tx_bit        <= '0;
            tx_cnt        <= '0;
            uart_tx       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: a UART transmitter model, a bus responder
// and a UART receiver monitor compare against queued expectations.
module tb_uart_bus_master;

   localparam int CPB = 20;

   typedef struct packed {
      logic        is_write;
      logic [31:0] addr;
      logic [31:0] data;
   } bus_txn_t;

   typedef logic [7:0] byte_q_t[$];

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        uart_rx = 1'b1;
   logic        uart_tx;
   logic [31:0] rw_address;
   logic [31:0] read_data = '0;
   logic        read_request;
   logic        read_response = 1'b0;
   logic [31:0] write_data;
   logic        write_request;
   logic        write_response = 1'b0;
   logic        busy;

   int          compared = 0;
   int          mismatched = 0;
   int          cyc = 0;
   int          unexpected_tx = 0;
   int          unexpected_bus = 0;
   int          resp_mode = 1;
   logic [31:0] rd_value = 32'h12345678;

   logic [7:0]  exp_tx[$];
   bus_txn_t    exp_bus[$];

   uart_bus_master #(
      .CLOCK_FREQUENCY(1000000),
      .UART_BAUD_RATE (50000),
      .BUS_TIMEOUT    (64)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .uart_rx       (uart_rx),
      .uart_tx       (uart_tx),
      .rw_address    (rw_address),
      .read_data     (read_data),
      .read_request  (read_request),
      .read_response (read_response),
      .write_data    (write_data),
      .write_request (write_request),
      .write_response(write_response),
      .busy          (busy)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task wait_cycles(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task applyStimulus(input logic [7:0] data, input logic stop_bit);
      uart_rx = 1'b0;
      wait_cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = data[i];
         wait_cycles(CPB);
      end
      uart_rx = stop_bit;
      wait_cycles(CPB);
      uart_rx = 1'b1;
      wait_cycles(2);
   endtask

   task send_queue(input byte_q_t q);
      foreach (q[i]) applyStimulus(q[i], 1'b1);
   endtask

   task wait_done(input string tag);
      int n;
      n = 0;
      while (busy && n < 5000) begin
         n++;
         wait_cycles(1);
      end
      checkOutput({tag, "_busy_fell"}, busy, 0);
      wait_cycles(CPB);
      checkOutput({tag, "_tx_left"}, exp_tx.size(), 0);
      checkOutput({tag, "_bus_left"}, exp_bus.size(), 0);
   endtask

   task check_reset_outputs(input string tag);
      checkOutput({tag, "_uart_tx"}, uart_tx, 1);
      checkOutput({tag, "_read_req"}, read_request, 0);
      checkOutput({tag, "_write_req"}, write_request, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_address"}, rw_address, 0);
      checkOutput({tag, "_wdata"}, write_data, 0);
   endtask

   // Receiver model: decodes each frame and compares it with the next queued byte.
   initial begin : tx_monitor
      logic [7:0] b;
      int last_start;
      int start_cyc;
      last_start = -1000;
      forever begin
         @(negedge uart_tx);
         if (rst_ni) begin
            start_cyc = cyc;
            if (start_cyc - last_start < 11 * CPB)
               checkOutput("tx_gap", start_cyc - last_start, 10 * CPB);
            last_start = start_cyc;
            wait_cycles(CPB / 2);
            checkOutput("tx_start", uart_tx, 0);
            for (int i = 0; i < 8; i++) begin
               wait_cycles(CPB);
               b[i] = uart_tx;
            end
            wait_cycles(CPB);
            checkOutput("tx_stop", uart_tx, 1);
            if (exp_tx.size() == 0) unexpected_tx++;
            else checkOutput("tx_byte", b, exp_tx.pop_front());
         end
      end
   end

   // Bus responder: acks one cycle after seeing a request, or never in timeout mode.
   initial begin : responder
      bus_txn_t e;
      int held;
      forever begin
         @(posedge clk_i);
         #1;
         if (rst_ni && (read_request || write_request)) begin
            checkOutput("req_exclusive", read_request && write_request, 0);
            if (exp_bus.size() == 0) begin
               unexpected_bus++;
            end else begin
               e = exp_bus.pop_front();
               checkOutput("bus_kind", write_request, e.is_write);
               checkOutput("bus_addr", rw_address, e.addr);
               if (e.is_write) checkOutput("bus_wdata", write_data, e.data);
            end
            if (resp_mode == 1) begin
               wait_cycles(1);
               read_data      = rd_value;
               read_response  = read_request;
               write_response = write_request;
               wait_cycles(1);
               read_response  = 1'b0;
               write_response = 1'b0;
               checkOutput("req_dropped", read_request | write_request, 0);
            end else begin
               held = 0;
               while ((read_request || write_request) && held < 200) begin
                  held++;
                  wait_cycles(1);
               end
               checkOutput("timeout_len", held, 64);
            end
         end
      end
   end

   initial begin : main
      wait_cycles(3);
      check_reset_outputs("reset");
      rst_ni = 1'b1;
      wait_cycles(5);

      exp_bus.push_back('{1'b1, 32'h80000000, 32'h00000041});
      exp_tx.push_back(8'h06);
      send_queue('{8'h57, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h41});
      wait_done("write");
      checkOutput("write_addr_hold", rw_address, 32'h80000000);
      checkOutput("write_data_hold", write_data, 32'h00000041);

      rd_value = 32'h12345678;
      exp_bus.push_back('{1'b0, 32'h80000004, 32'h0});
      exp_tx.push_back(8'h12);
      exp_tx.push_back(8'h34);
      exp_tx.push_back(8'h56);
      exp_tx.push_back(8'h78);
      send_queue('{8'h52, 8'h80, 8'h00, 8'h00, 8'h04});
      wait_done("read");

      resp_mode = 2;
      exp_bus.push_back('{1'b0, 32'h00001000, 32'h0});
      exp_tx.push_back(8'h15);
      send_queue('{8'h52, 8'h00, 8'h00, 8'h10, 8'h00});
      wait_done("timeout");
      resp_mode = 1;

      exp_tx.push_back(8'h15);
      applyStimulus(8'h99, 1'b1);
      wait_done("bad_cmd");

      applyStimulus(8'h57, 1'b0);
      wait_cycles(2 * CPB);
      checkOutput("framing_idle", busy, 0);
      exp_bus.push_back('{1'b1, 32'h00000010, 32'hAABBCCDD});
      exp_tx.push_back(8'h06);
      send_queue('{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
      wait_done("after_ferr");

      send_queue('{8'h52, 8'h11, 8'h22});
      uart_rx = 1'b0;
      wait_cycles(3 * CPB);
      rst_ni = 1'b0;
      wait_cycles(2);
      check_reset_outputs("midcmd_reset");
      uart_rx = 1'b1;
      wait_cycles(3);
      rst_ni = 1'b1;
      wait_cycles(3 * CPB);
      rd_value = 32'hCAFEF00D;
      exp_bus.push_back('{1'b0, 32'h00000020, 32'h0});
      exp_tx.push_back(8'hCA);
      exp_tx.push_back(8'hFE);
      exp_tx.push_back(8'hF0);
      exp_tx.push_back(8'h0D);
      send_queue('{8'h52, 8'h00, 8'h00, 8'h00, 8'h20});
      wait_done("after_reset");

      uart_rx = 1'b0;
      wait_cycles(5);
      uart_rx = 1'b1;
      wait_cycles(12 * CPB);
      checkOutput("glitch_idle", busy, 0);

      checkOutput("tx_unexpected", unexpected_tx, 0);
      checkOutput("bus_unexpected", unexpected_bus, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
